// File: rtl/id_scoreboard.sv
// ---------------------------------------------------------------------------
// id_scoreboard
//
// Decode-stage register scoreboard. Each architectural register carries a
// small down-counter (cycles until its pending result is bypassable) and a
// flag for unbounded-latency producers (divider) that are released only by
// an explicit wb_clr. Decode is stalled while any enabled source is still
// pending, or when a write would let an older result land after this one.
//
// Optional feature macro: SCOREBOARD_STATS_EN
//   When defined, adds saturating 32-bit counters of stall cycles and of
//   WAW-stall cycles (ports stall_cycles, waw_cycles), cleared by rst.
//
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   issue_valid  decode holds an instruction that wants to issue
//   flush        kill the decode instruction; no scoreboard write
//   re, raddr    per-port source read enable / address (port i at [i*AW +: AW])
//   we, waddr    issuing instruction writes register waddr
//   lat, lat_unb bounded result latency 1..MAX_LAT, or unbounded producer
//   wb_clr       release of the unbounded producer targeting wb_addr
//   stall        combinational decode hold
//   issue_fire   issue_valid & ~stall & ~flush
//   src_busy     per-port hazard flag
//   busy_vec     per-register pending flag straight from state; bit 0 is 0
// ---------------------------------------------------------------------------
module id_scoreboard #(
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int MAX_LAT = 4,
    parameter int AW      = $clog2(NREG),
    parameter int LW      = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              flush,
    input  logic [NRD-1:0]    re,
    input  logic [NRD*AW-1:0] raddr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [LW-1:0]     lat,
    input  logic              lat_unb,
    input  logic              wb_clr,
    input  logic [AW-1:0]     wb_addr,
    output logic              stall,
    output logic              issue_fire,
    output logic [NRD-1:0]    src_busy,
    output logic [NREG-1:0]   busy_vec
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       waw_cycles
`endif
);

    logic [LW-1:0]   cnt_q [NREG];
    logic [LW-1:0]   cnt_d [NREG];
    logic [NREG-1:0] unb_q;
    logic [NREG-1:0] unb_d;
    logic            waw;
    logic            wr_en;

    genvar gi;
    generate
        // Register 0 is hardwired to zero, so it can never be pending.
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_vec[gi] = 1'b0;
            end else begin : g_track
                assign busy_vec[gi] = (cnt_q[gi] != '0) | unb_q[gi];
            end
        end
        for (gi = 0; gi < NRD; gi++) begin : g_src
            assign src_busy[gi] = re[gi] & busy_vec[raddr[gi*AW +: AW]];
        end
    endgenerate

    // A new bounded write must not finish before an older pending write to
    // the same register; an equal or shorter remaining count is harmless
    // because the new value overwrites the tracking state anyway.
    assign waw = we & (waddr != '0) &
                 (unb_q[waddr] | (~lat_unb & (cnt_q[waddr] > lat)));

    assign stall      = issue_valid & ~flush & ((|src_busy) | waw);
    assign issue_fire = issue_valid & ~stall & ~flush;
    assign wr_en      = issue_fire & we & (waddr != '0);

    // Next state: age every counter, apply releases, then let the issuing
    // write override both for its own destination.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : cnt_q[r];
            unb_d[r] = unb_q[r];
        end
        if (wb_clr) begin
            unb_d[wb_addr] = 1'b0;
        end
        if (wr_en) begin
            if (lat_unb) begin
                unb_d[waddr] = 1'b1;
                cnt_d[waddr] = '0;
            end else begin
                // lat==0 leaves the register untracked (already bypassable).
                unb_d[waddr] = 1'b0;
                cnt_d[waddr] = lat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            unb_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            unb_q <= unb_d;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] waw_cycles_q;
    logic [31:0] waw_cycles_d;
    logic        waw_stall;

    assign waw_stall = issue_valid & ~flush & waw;

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        waw_cycles_d   = waw_cycles_q;
        if (stall && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (waw_stall && !(&waw_cycles_q)) begin
            waw_cycles_d = waw_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            waw_cycles_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            waw_cycles_q   <= waw_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign waw_cycles   = waw_cycles_q;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_scoreboard
//
// Table-driven bench for id_scoreboard (NREG=32, NRD=2, MAX_LAT=4). Each
// vector is one decode cycle: inputs, the expected combinational outputs
// during that cycle, and the expected busy_vec after the clock edge.
// Expected results go through a queue: pushed when a vector is driven and
// popped when the DUT outputs are sampled. Divider release and reset are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_id_scoreboard;

    localparam int NREG    = 32;
    localparam int NRD     = 2;
    localparam int MAX_LAT = 4;
    localparam int AW      = 5;
    localparam int LW      = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic              flush;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] raddr;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [LW-1:0]     lat;
    logic              lat_unb;
    logic              wb_clr;
    logic [AW-1:0]     wb_addr;
    logic              stall;
    logic              issue_fire;
    logic [NRD-1:0]    src_busy;
    logic [NREG-1:0]   busy_vec;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       waw_cycles;
`endif

    id_scoreboard #(
        .NREG    (NREG),
        .NRD     (NRD),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .flush       (flush),
        .re          (re),
        .raddr       (raddr),
        .we          (we),
        .waddr       (waddr),
        .lat         (lat),
        .lat_unb     (lat_unb),
        .wb_clr      (wb_clr),
        .wb_addr     (wb_addr),
        .stall       (stall),
        .issue_fire  (issue_fire),
        .src_busy    (src_busy),
        .busy_vec    (busy_vec)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .waw_cycles  (waw_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Bounded latency above MAX_LAT is illegal stimulus.
    always @(posedge clk) begin
        if (!rst && issue_valid && we && !lat_unb) begin
            assert (int'(lat) <= MAX_LAT) else $error("lat %0d out of range", lat);
        end
    end

    typedef struct {
        logic            iv;
        logic            fl;
        logic [1:0]      re;
        logic [4:0]      ra0;
        logic [4:0]      ra1;
        logic            we;
        logic [4:0]      wa;
        logic [2:0]      lat;
        logic            unb;
        logic            e_stall;
        logic            e_fire;
        logic [1:0]      e_src;
        logic [31:0]     e_busy;
    } vec_t;

    typedef struct {
        logic        stall;
        logic        fire;
        logic [1:0]  src;
        logic [31:0] busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // eb < 0 means no register pending after the edge.
    function automatic vec_t mk(int iv, int fl, int rev, int ra0, int ra1,
                                int wev, int wa, int lt, int ub,
                                int es, int ef, int esrc, int eb);
        vec_t v;
        v.iv      = 1'(iv);
        v.fl      = 1'(fl);
        v.re      = 2'(rev);
        v.ra0     = 5'(ra0);
        v.ra1     = 5'(ra1);
        v.we      = 1'(wev);
        v.wa      = 5'(wa);
        v.lat     = 3'(lt);
        v.unb     = 1'(ub);
        v.e_stall = 1'(es);
        v.e_fire  = 1'(ef);
        v.e_src   = 2'(esrc);
        v.e_busy  = (eb < 0) ? 32'h0 : (32'h1 << eb);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive(vec_t v, logic wbc, logic [4:0] wba);
        issue_valid = v.iv;
        flush       = v.fl;
        re          = v.re;
        raddr       = {v.ra1, v.ra0};
        we          = v.we;
        waddr       = v.wa;
        lat         = v.lat;
        lat_unb     = v.unb;
        wb_clr      = wbc;
        wb_addr     = wba;
    endtask

    // One cycle: drive at negedge, check comb outputs mid-cycle, check
    // busy_vec just after the following rising edge.
    task automatic step(string tag, vec_t v, logic wbc, logic [4:0] wba, override_busy_en, logic [31:0] override_busy);
        exp_t e;
        exp_t got;
        @(negedge clk);
        drive(v, wbc, wba);
        e.stall = v.e_stall;
        e.fire  = v.e_fire;
        e.src   = v.e_src;
        e.busy  = override_busy_en ? override_busy : v.e_busy;
        exp_q.push_back(e);
        #1;
        got = exp_q.pop_front();
        chk({tag, " stall"}, 32'(stall), 32'(got.stall));
        chk({tag, " fire"},  32'(issue_fire), 32'(got.fire));
        chk({tag, " src_busy"}, 32'(src_busy), 32'(got.src));
        @(posedge clk);
        #1;
        chk({tag, " busy_vec"}, busy_vec, got.busy);
        $display("%s: iv=%0b fl=%0b re=%b we=%0b wa=%0d lat=%0d unb=%0b -> stall=%0b fire=%0b busy=%h",
                 tag, v.iv, v.fl, v.re, v.we, v.wa, v.lat, v.unb, stall, issue_fire, busy_vec);
    endtask

    vec_t tbl[25];

    initial begin
        vec_t v;

        // idle, LW r5 lat=2, idle, ADD r1,r5,r2 (stall while cnt5==1)
        tbl[0]  = mk(1,0,0,0,0, 1,5,2,0, 0,1,0, 5);
        tbl[1]  = mk(0,0,0,0,0, 0,0,0,0, 0,0,0, 5);
        tbl[2]  = mk(1,0,3,5,2, 1,1,1,0, 1,0,1, -1);
        tbl[3]  = mk(1,0,3,5,2, 1,1,1,0, 0,1,0, 1);
        tbl[4]  = mk(0,0,0,0,0, 0,0,0,0, 0,0,0, -1);
        // back-to-back consumer on port 1 of a lat=1 result: one stall
        tbl[5]  = mk(1,0,0,0,0, 1,5,1,0, 0,1,0, 5);
        tbl[6]  = mk(1,0,2,0,5, 0,0,0,0, 1,0,2, -1);
        tbl[7]  = mk(1,0,2,0,5, 0,0,0,0, 0,1,0, -1);
        // register 0 write and read: never tracked
        tbl[8]  = mk(1,0,0,0,0, 1,0,4,0, 0,1,0, -1);
        tbl[9]  = mk(1,0,3,0,0, 0,0,0,0, 0,1,0, -1);
        // WAW: r7 lat=4 then r7 lat=1 waits until cnt<=1, then r7 lat=3
        tbl[10] = mk(1,0,0,0,0, 1,7,4,0, 0,1,0, 7);
        tbl[11] = mk(1,0,0,0,0, 1,7,1,0, 1,0,0, 7);
        tbl[12] = mk(1,0,0,0,0, 1,7,1,0, 1,0,0, 7);
        tbl[13] = mk(1,0,0,0,0, 1,7,1,0, 1,0,0, 7);
        tbl[14] = mk(1,0,0,0,0, 1,7,1,0, 0,1,0, 7);
        tbl[15] = mk(1,0,0,0,0, 1,7,3,0, 0,1,0, 7);
        tbl[16] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0, 7);
        tbl[17] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0, 7);
        tbl[18] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0, -1);
        // flush: no write; flushed consumer of a busy source does not stall
        tbl[19] = mk(1,1,0,0,0, 1,9,3,0, 0,0,0, -1);
        tbl[20] = mk(1,0,0,0,0, 1,9,2,0, 0,1,0, 9);
        tbl[21] = mk(1,1,1,9,0, 0,0,0,0, 0,0,1, 9);
        tbl[22] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0, -1);
        // lat=0: no tracking
        tbl[23] = mk(1,0,0,0,0, 1,10,0,0, 0,1,0, -1);
        tbl[24] = mk(1,0,1,10,0, 0,0,0,0, 0,1,0, -1);

        // Reset
        rst = 1'b1;
        drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,-1), 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy_vec", busy_vec, 32'h0);
        chk("reset stall", 32'(stall), 32'h0);
        chk("reset fire", 32'(issue_fire), 32'h0);
`ifdef SCOREBOARD_STATS_EN
        chk("reset stall_cycles", stall_cycles, 32'h0);
        chk("reset waw_cycles", waw_cycles, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            step($sformatf("vec%0d", i), tbl[i], 1'b0, 5'd0, 1'b0, 32'h0);
        end

        // Divider: consumer of r3 held 20 cycles, released by wb_clr in the last
        step("div_issue", mk(1,0,0,0,0, 1,3,0,1, 0,1,0, 3), 1'b0, 5'd0, 1'b0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            v = mk(1,0,1,3,0, 0,0,0,0, 1,0,1, (k == 19) ? -1 : 3);
            step($sformatf("div_wait%0d", k), v, (k == 19), 5'd3, 1'b0, 32'h0);
        end
        step("div_use", mk(1,0,1,3,0, 0,0,0,0, 0,1,0, -1), 1'b0, 5'd0, 1'b0, 32'h0);
        // wb_clr to a bounded-tracked register leaves its counter alone
        step("bnd_r3", mk(1,0,0,0,0, 1,3,2,0, 0,1,0, 3), 1'b0, 5'd0, 1'b0, 32'h0);
        step("wbclr_nop", mk(0,0,0,0,0, 0,0,0,0, 0,0,0, 3), 1'b1, 5'd3, 1'b0, 32'h0);
        step("drain_r3", mk(0,0,0,0,0, 0,0,0,0, 0,0,0, -1), 1'b0, 5'd0, 1'b0, 32'h0);

        // Reset with r4 cnt=3 and r6 unbounded pending
        step("unb_r6", mk(1,0,0,0,0, 1,6,0,1, 0,1,0, 6), 1'b0, 5'd0, 1'b0, 32'h0);
        step("lat3_r4", mk(1,0,0,0,0, 1,4,3,0, 0,1,0, 4), 1'b0, 5'd0, 1'b1, 32'h0000_0050);
        @(negedge clk);
        drive(mk(1,0,1,4,0, 0,0,0,0, 0,0,0,-1), 1'b0, 5'd0);
        rst = 1'b1;
        #1;
        chk("pre_rst stall", 32'(stall), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst busy_vec", busy_vec, 32'h0);
        chk("post_rst stall", 32'(stall), 32'h0);
`ifdef SCOREBOARD_STATS_EN
        chk("post_rst stall_cycles", stall_cycles, 32'h0);
        chk("post_rst waw_cycles", waw_cycles, 32'h0);
`endif
        $display("rst pulse: stall=%0b busy=%h", stall, busy_vec);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_use", mk(1,0,1,4,0, 0,0,0,0, 0,1,0, -1), 1'b0, 5'd0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
